// File: rtl/ppi_strobed_port.sv
// Strobed parallel port: CPU register interface with one FIFO per direction and synchronised peripheral handshakes.
// Optional interrupt logic is built when PPI_STROBED_PORT_INTR_EN is defined.
module ppi_strobed_port #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             rdb,
    input  logic             wrb,
    input  logic [1:0]       address,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out,
    input  logic [WIDTH-1:0] port_in,
    input  logic             stbb,
    input  logic             ackb,
    output logic [WIDTH-1:0] port_out,
    output logic             port_oe,
    output logic             ibf,
    output logic             obfb,
    output logic             intr
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic stb_s1, stb_s2, stb_d, ack_s1, ack_s2, ack_d, rdb_d, wrb_d;
    logic [WIDTH-1:0] in_mem [DEPTH];
    logic [WIDTH-1:0] out_mem [DEPTH];
    logic [AW-1:0] in_wp, in_rp, out_wp, out_rp;
    logic [AW:0] in_cnt, out_cnt;
    logic in_ovf, out_ovf, rd_unf;
    logic rd_stb, wr_stb, st_clr;
    logic in_push, in_pop_req, in_pop, in_wr, in_ne, in_full;
    logic out_push, out_pop, out_wr, out_ne, out_full;
    logic [WIDTH-1:0] status_word, ctrl_word, rd_word;

    assign rd_stb     = rdb_d & ~rdb;
    assign wr_stb     = wrb_d & ~wrb;
    assign st_clr     = rd_stb && (address == 2'd1);

    assign in_ne      = (in_cnt != '0);
    assign in_full    = (in_cnt == FULL_CNT);
    assign in_push    = stb_d & ~stb_s2;
    assign in_pop_req = rd_stb && (address == 2'd0);
    assign in_pop     = in_pop_req & in_ne;
    assign in_wr      = in_push & (~in_full | in_pop);

    assign out_ne     = (out_cnt != '0);
    assign out_full   = (out_cnt == FULL_CNT);
    assign out_push   = wr_stb && (address == 2'd0);
    assign out_pop    = ack_s2 & ~ack_d & out_ne;
    assign out_wr     = out_push & (~out_full | out_pop);

    assign ibf      = in_ne;
    assign obfb     = ~out_ne;
    assign port_oe  = ~ack_s2;
    assign port_out = out_ne ? out_mem[out_rp] : '0;

    // Synchronisers idle high so a strobe held low across reset release still produces one edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stb_s1 <= 1'b1;
            stb_s2 <= 1'b1;
            stb_d  <= 1'b1;
            ack_s1 <= 1'b1;
            ack_s2 <= 1'b1;
            ack_d  <= 1'b1;
            rdb_d  <= 1'b1;
            wrb_d  <= 1'b1;
        end else begin
            stb_s1 <= stbb;
            stb_s2 <= stb_s1;
            stb_d  <= stb_s2;
            ack_s1 <= ackb;
            ack_s2 <= ack_s1;
            ack_d  <= ack_s2;
            rdb_d  <= rdb;
            wrb_d  <= wrb;
        end
    end

    always_ff @(posedge clk) begin
        if (in_wr)  in_mem[in_wp]   <= port_in;
        if (out_wr) out_mem[out_wp] <= data_in;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            in_wp   <= '0;
            in_rp   <= '0;
            in_cnt  <= '0;
            out_wp  <= '0;
            out_rp  <= '0;
            out_cnt <= '0;
        end else begin
            if (in_wr)  in_wp  <= in_wp + 1'b1;
            if (in_pop) in_rp  <= in_rp + 1'b1;
            if (in_wr && !in_pop)      in_cnt <= in_cnt + 1'b1;
            else if (!in_wr && in_pop) in_cnt <= in_cnt - 1'b1;
            if (out_wr)  out_wp <= out_wp + 1'b1;
            if (out_pop) out_rp <= out_rp + 1'b1;
            if (out_wr && !out_pop)      out_cnt <= out_cnt + 1'b1;
            else if (!out_wr && out_pop) out_cnt <= out_cnt - 1'b1;
        end
    end

    // A flag event in the clearing cycle takes priority over the status-read clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            in_ovf  <= 1'b0;
            out_ovf <= 1'b0;
            rd_unf  <= 1'b0;
        end else begin
            in_ovf  <= (in_push & in_full & ~in_pop) | (in_ovf & ~st_clr);
            out_ovf <= (out_push & out_full & ~out_pop) | (out_ovf & ~st_clr);
            rd_unf  <= (in_pop_req & ~in_ne) | (rd_unf & ~st_clr);
        end
    end

`ifdef PPI_STROBED_PORT_INTR_EN
    logic inte_in, inte_out, intr_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            inte_in  <= 1'b0;
            inte_out <= 1'b0;
            intr_q   <= 1'b0;
        end else begin
            if (wr_stb && (address == 2'd2)) begin
                inte_in  <= data_in[0];
                inte_out <= data_in[1];
            end
            intr_q <= (inte_in & in_ne) | (inte_out & ~out_ne);
        end
    end

    assign intr = intr_q;
`else
    assign intr = 1'b0;
`endif

    always_comb begin
        status_word      = '0;
        status_word[7:0] = {intr, rd_unf, out_ovf, in_ovf, out_full, out_ne, in_full, in_ne};
        ctrl_word        = '0;
`ifdef PPI_STROBED_PORT_INTR_EN
        ctrl_word[1:0]   = {inte_out, inte_in};
`endif
        case (address)
            2'd0:    rd_word = in_ne ? in_mem[in_rp] : '0;
            2'd1:    rd_word = status_word;
            2'd2:    rd_word = ctrl_word;
            default: rd_word = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)       data_out <= '0;
        else if (rd_stb) data_out <= rd_word;
    end
endmodule

// File: tb/tb_ppi_strobed_port.sv
// Scoreboard bench for ppi_strobed_port: reads queue their expected data, a bus monitor checks data_out.
// Interrupt expectations follow PPI_STROBED_PORT_INTR_EN.
module tb_ppi_strobed_port;
`ifdef PPI_STROBED_PORT_INTR_EN
    localparam bit INTR_EN = 1'b1;
`else
    localparam bit INTR_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset, rdb, wrb, stbb, ackb;
    logic [1:0] address;
    logic [7:0] data_in, data_out, port_in, port_out;
    logic       port_oe, ibf, obfb, intr;

    logic [7:0] exp_q[$];
    int n_checks = 0;
    int n_fail   = 0;

    ppi_strobed_port #(.WIDTH(8), .DEPTH(4)) dut (
        .clk(clk), .reset(reset), .rdb(rdb), .wrb(wrb), .address(address),
        .data_in(data_in), .data_out(data_out), .port_in(port_in), .stbb(stbb),
        .ackb(ackb), .port_out(port_out), .port_oe(port_oe), .ibf(ibf),
        .obfb(obfb), .intr(intr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr(input logic [1:0] a, input logic [7:0] d);
        address = a; data_in = d; wrb = 1'b0;
        tick(1);
        wrb = 1'b1;
        tick(1);
    endtask

    task automatic rd(input logic [1:0] a, input logic [7:0] e);
        exp_q.push_back(e);
        address = a; rdb = 1'b0;
        tick(1);
        rdb = 1'b1;
        tick(1);
    endtask

    task automatic strobe(input logic [7:0] v);
        port_in = v; stbb = 1'b0;
        tick(4);
        stbb = 1'b1;
        tick(3);
    endtask

    task automatic ack_pulse();
        ackb = 1'b0;
        tick(4);
        ackb = 1'b1;
        tick(4);
    endtask

    // Bus monitor: a read is a low rdb sample following a high one; data_out is checked half a cycle later.
    initial begin
        logic       rd_last;
        logic [7:0] e;
        rd_last = 1'b1;
        forever begin
            @(posedge clk);
            if (reset) rd_last = 1'b1;
            else if (!rdb && rd_last) begin
                rd_last = 1'b0;
                @(negedge clk);
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected read: got %0h expected no read", data_out);
                end else begin
                    e = exp_q.pop_front();
                    chk("read data", data_out, e);
                end
            end else rd_last = rdb;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; rdb = 1'b1; wrb = 1'b1; stbb = 1'b1; ackb = 1'b1;
        address = 2'd0; data_in = 8'h00; port_in = 8'h00;
        tick(3);
        chk("reset data_out", data_out, 8'h00);
        chk("reset ibf", ibf, 1'b0);
        chk("reset obfb", obfb, 1'b1);
        chk("reset port_oe", port_oe, 1'b0);
        chk("reset intr", intr, 1'b0);
        chk("reset port_out", port_out, 8'h00);
        reset = 1'b0;
        tick(2);

        // Output path handshake
        wr(2'd0, 8'hAA);
        chk("obfb after write", obfb, 1'b0);
        chk("port_out after write", port_out, 8'hAA);
        ackb = 1'b0;
        tick(3);
        chk("port_oe during ack", port_oe, 1'b1);
        tick(1);
        ackb = 1'b1;
        tick(4);
        chk("obfb after ack", obfb, 1'b1);
        chk("port_oe after ack", port_oe, 1'b0);

        // Input strobe latency
        port_in = 8'hA5; stbb = 1'b0;
        tick(2);
        chk("ibf before latency", ibf, 1'b0);
        tick(1);
        chk("ibf at latency", ibf, 1'b1);
        tick(1);
        stbb = 1'b1;
        tick(3);
        rd(2'd0, 8'hA5);
        chk("ibf after read", ibf, 1'b0);

        // Input overflow and ordering
        for (int i = 1; i <= 5; i++) strobe(8'(i));
        rd(2'd1, 8'h13);
        for (int i = 1; i <= 4; i++) rd(2'd0, 8'(i));
        rd(2'd1, 8'h00);

        // Underflow
        rd(2'd0, 8'h00);
        rd(2'd1, 8'h40);
        rd(2'd1, 8'h00);

        // Full input FIFO: push and pop in the same cycle
        for (int i = 0; i < 4; i++) strobe(8'h11 + 8'(i));
        port_in = 8'h15; stbb = 1'b0;
        tick(2);
        exp_q.push_back(8'h11);
        address = 2'd0; rdb = 1'b0;
        tick(1);
        rdb = 1'b1;
        tick(2);
        stbb = 1'b1;
        tick(3);
        rd(2'd1, 8'h03);
        for (int i = 0; i < 4; i++) rd(2'd0, 8'h12 + 8'(i));
        rd(2'd1, 8'h00);

        // Input interrupt
        wr(2'd2, 8'h01);
        rd(2'd2, INTR_EN ? 8'h01 : 8'h00);
        strobe(8'h5A);
        chk("intr on ibf", intr, INTR_EN);
        rd(2'd1, INTR_EN ? 8'h81 : 8'h01);
        rd(2'd0, 8'h5A);
        tick(2);
        chk("intr after read", intr, 1'b0);
        wr(2'd2, 8'h00);

        // Output overflow and drain order
        for (int i = 0; i < 5; i++) wr(2'd0, 8'h21 + 8'(i));
        rd(2'd1, 8'h2C);
        for (int i = 0; i < 4; i++) begin
            chk("port_out order", port_out, 8'h21 + 8'(i));
            ack_pulse();
        end
        chk("obfb drained", obfb, 1'b1);
        ack_pulse();
        chk("obfb empty ack", obfb, 1'b1);
        chk("port_out empty", port_out, 8'h00);
        rd(2'd1, 8'h00);

        // Output interrupt
        wr(2'd0, 8'h31);
        wr(2'd2, 8'h02);
        tick(2);
        chk("intr out busy", intr, 1'b0);
        ack_pulse();
        tick(1);
        chk("intr out empty", intr, INTR_EN);
        wr(2'd2, 8'h00);
        tick(2);
        chk("intr disabled", intr, 1'b0);

        // Ignored writes
        wr(2'd1, 8'hFF);
        wr(2'd3, 8'hFF);
        rd(2'd1, 8'h00);
        rd(2'd2, 8'h00);
        rd(2'd3, 8'h00);

        // Reset mid-handshake, stbb held low through release
        wr(2'd0, 8'h77);
        ackb = 1'b0;
        tick(1);
        reset = 1'b1; stbb = 1'b0; port_in = 8'h3C;
        tick(2);
        chk("mid reset obfb", obfb, 1'b1);
        chk("mid reset port_oe", port_oe, 1'b0);
        chk("mid reset ibf", ibf, 1'b0);
        chk("mid reset data_out", data_out, 8'h00);
        chk("mid reset port_out", port_out, 8'h00);
        ackb = 1'b1;
        reset = 1'b0;
        tick(2);
        chk("held stbb before latency", ibf, 1'b0);
        tick(1);
        chk("held stbb at latency", ibf, 1'b1);
        tick(3);
        stbb = 1'b1;
        tick(3);
        rd(2'd0, 8'h3C);
        rd(2'd1, 8'h00);
        chk("obfb after reset", obfb, 1'b1);

        tick(2);
        chk("scoreboard drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/ppi_strobed_port.md
PPI_STROBED_PORT -- requirements
Module: ppi_strobed_port

Interface
REQ-001 Parameter WIDTH, default 8, meaning port and data width in bits; legal values 8..32.
REQ-002 Parameter DEPTH, default 4, meaning entries per direction FIFO; power of two, 2..16.
REQ-003 clk  input  1  sole clock; all state is updated on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset; clears all state immediately.
REQ-005 rdb  input  1  active-low CPU read strobe, synchronous to clk.
REQ-006 wrb  input  1  active-low CPU write strobe, synchronous to clk.
REQ-007 address  input  2  register select: 0 data, 1 status, 2 control, 3 reserved.
REQ-008 data_in  input  WIDTH  CPU write data.
REQ-009 data_out  output  WIDTH  registered CPU read data.
REQ-010 port_in  input  WIDTH  peripheral input data; stable while stbb is low.
REQ-011 stbb  input  1  active-low peripheral strobe, asynchronous.
REQ-012 ackb  input  1  active-low peripheral acknowledge, asynchronous.
REQ-013 port_out  output  WIDTH  output FIFO head.
REQ-014 port_oe  output  1  port_out drive enable; high only while synchronised ackb is low.
REQ-015 ibf  output  1  input FIFO non-empty.
REQ-016 obfb  output  1  active-low; low while output FIFO is non-empty.
REQ-017 intr  output  1  interrupt request.

Function
REQ-018 Each of stbb and ackb passes through a 2-flop synchroniser; edges are detected on the synchronised value against a registered copy. Latency is 3 clk from pin edge to action.
REQ-019 A synchronised stbb falling edge pushes port_in into the input FIFO.
REQ-020 A synchronised ackb rising edge pops the output FIFO.
REQ-021 A wrb falling edge (previous sample 1, current sample 0) is a write; an rdb falling edge is a read. Exactly one action occurs per strobe.
REQ-022 Write to address 0 pushes data_in[WIDTH-1:0] into the output FIFO.
REQ-023 Write to address 2 loads data_in[0] into inte_in and data_in[1] into inte_out.
REQ-024 Writes to address 1 or address 3 are ignored.
REQ-025 Read from address 0 loads the input FIFO head into data_out on the next clk edge and pops the FIFO.
REQ-026 Read from address 0 when the input FIFO is empty loads 0, leaves the pointers unchanged and sets rd_unf.
REQ-027 Status word, zero-extended to WIDTH: bit0 ibf, bit1 in_full, bit2 out_nonempty, bit3 out_full, bit4 in_ovf, bit5 out_ovf, bit6 rd_unf, bit7 intr.
REQ-028 Read from address 1 returns the status word; in_ovf, out_ovf and rd_unf clear on the same edge. A flag event in that same cycle wins and leaves the flag set.
REQ-029 Read from address 2 returns {inte_out, inte_in} in bits [1:0]; read from address 3 returns 0.
REQ-030 A push to a full FIFO with no simultaneous pop is dropped and sets in_ovf (input FIFO) or out_ovf (output FIFO).
REQ-031 A simultaneous push and pop on one FIFO both succeed; the count is unchanged, including when the FIFO is full.
REQ-032 A pop of an empty output FIFO (ackb with no data) is ignored.
REQ-033 Pointers wrap modulo DEPTH; the count is log2(DEPTH)+1 bits wide.
REQ-034 ibf, obfb and port_out reflect FIFO state one clk after the push or pop.

Reset
REQ-035 Reset clears both FIFOs, all flags, inte_in and inte_out.
REQ-036 Reset drives data_out=0, ibf=0, obfb=1, port_oe=0, intr=0 and port_out=0.
REQ-037 Synchroniser and edge flops reset to 1; stbb held low through reset release yields exactly one push 3 clk after release.
REQ-038 Reset mid-handshake aborts it; any partial strobe is not completed.

Configuration
REQ-039 Macro PPI_STROBED_PORT_INTR_EN defined: intr = (inte_in & ibf) | (inte_out & ~out_nonempty), registered.
REQ-040 Macro absent: intr is tied 0, inte bits are not stored, and address 2 reads 0; all other behaviour is identical.

Verification
REQ-041 Reset, then write 0xAA to address 0 -> obfb=0 and port_out=0xAA; pulse ackb low then high -> port_oe is high during the pulse, then obfb=1.
REQ-042 Pulse stbb low with port_in=0xA5 -> ibf=1 3 clk later; read address 0 -> data_out=0xA5 and ibf=0.
REQ-043 DEPTH=4: five stbb pulses with 0x01..0x05, then status read -> bit1=1 and bit4=1; four data reads return 0x01..0x04; a second status read shows bit4=0.
REQ-044 Read address 0 while the input FIFO is empty -> data_out=0x00 and status bit6=1.
REQ-045 Input FIFO full, then stbb edge and CPU read in the same cycle -> no overflow, count stays 4, order preserved.
REQ-046 With PPI_STROBED_PORT_INTR_EN: write 0x01 to address 2, then push via stbb -> intr=1; read the data -> intr=0. Without the macro, intr stays 0 throughout.
